fsm_counter_dispatcher: RTL and testbench

//  Initiator side of the counter run/idle/done interface: queues count jobs from upstream and

---
 rtl/fsm_counter_dispatcher.sv | 199 +++++++++++++++++++
 tb/tb_fsm_counter_dispatcher.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_counter_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : fsm_counter_dispatcher
// Description : Initiator for a run/idle/done counter worker. Jobs from an
//               upstream valid/ready source are queued in a small FIFO and
//               launched one at a time: a 1-cycle run pulse, the count held
//               stable until done, then a wait for the worker to return to idle.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CNT_W          job count width (matches worker i_num_cnt)
//   DEPTH          job FIFO entries (power of 2, >= 2)
//   TIMEOUT_CYCLES S_WAIT watchdog limit (used only with the macro below)
// Optional feature
//   FSM_DISPATCH_TIMEOUT_EN : enables the S_WAIT watchdog, o_timeout and o_err.
//                             Undefined: no watchdog, o_timeout/o_err tied to 0.
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   i_job_valid/i_job_num upstream job; o_job_ready = FIFO not full
//   o_run, o_num_cnt      launch pulse and count value to the worker
//   i_idle, i_running,    worker status (i_running is informational only)
//   i_done
//   o_busy, o_empty       FSM not idle, FIFO empty
//   o_jobs_done           completed-job counter (wraps)
//   o_timeout, o_err      watchdog expiry pulse, sticky error
// ============================================================================
module fsm_counter_dispatcher #(
  parameter int CNT_W          = 7,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_job_valid,
  input  logic [CNT_W-1:0] i_job_num,
  output logic             o_job_ready,
  output logic             o_run,
  output logic [CNT_W-1:0] o_num_cnt,
  input  logic             i_idle,
  input  logic             i_running,
  input  logic             i_done,
  output logic             o_busy,
  output logic             o_empty,
  output logic [15:0]      o_jobs_done,
  output logic             o_timeout,
  output logic             o_err
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  // --------------------------------------------------------------------------
  // Job FIFO: pointers carry one extra wrap bit to tell full from empty.
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             fifo_full, fifo_empty;
  logic             push, push_store, pop;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign push       = i_job_valid && !fifo_full;
  // Zero-length jobs complete the handshake but are never queued.
  assign push_store = push && (i_job_num != '0);

  always_ff @(posedge clk) begin
    if (push_store) begin
      mem_q[wr_ptr_q[AW-1:0]] <= i_job_num;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_store) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)        rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Dispatch FSM
  // --------------------------------------------------------------------------
  logic [1:0]       state_q, state_d;
  logic             jobs_inc;
  logic             expire;
  logic             run_q;
  logic             busy_q;
  logic [CNT_W-1:0] num_cnt_q;
  logic [15:0]      jobs_q;

`ifdef FSM_DISPATCH_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wdog_q;
  logic            timeout_q;
  logic            err_q;
  logic            wdog_hit;

  // wdog_q holds the number of completed S_WAIT cycles, so the hit fires on
  // the TIMEOUT_CYCLES-th cycle spent waiting.
  assign wdog_hit = (wdog_q == WD_LAST);
`endif

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    jobs_inc = 1'b0;
    expire   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty && i_idle) begin
          pop     = 1'b1;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        // A done arriving on the expiry cycle takes precedence.
        if (i_done) begin
          state_d  = S_DONE;
          jobs_inc = 1'b1;
        end
`ifdef FSM_DISPATCH_TIMEOUT_EN
        else if (wdog_hit) begin
          state_d = S_DONE;
          expire  = 1'b1;
        end
`endif
      end
      S_DONE: begin
        // Hold here until the done pulse is gone so it is counted once.
        if (!i_done && i_idle) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      run_q     <= 1'b0;
      busy_q    <= 1'b0;
      num_cnt_q <= '0;
      jobs_q    <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= pop;
      busy_q  <= (state_d != S_IDLE);
      if (pop) num_cnt_q <= mem_q[rd_ptr_q[AW-1:0]];
      jobs_q  <= jobs_q + 16'(jobs_inc);
    end
  end

`ifdef FSM_DISPATCH_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // Outside S_WAIT the counter is held at zero, which clears it on entry.
      if (state_q == S_WAIT) wdog_q <= wdog_q + 1'b1;
      else                   wdog_q <= '0;
      timeout_q <= expire;
      if (expire) err_q <= 1'b1;
    end
  end

  assign o_timeout = timeout_q;
  assign o_err     = err_q;

  logic unused_sink;
  assign unused_sink = i_running;
`else
  assign o_timeout = 1'b0;
  assign o_err     = 1'b0;

  logic unused_sink;
  assign unused_sink = i_running ^ expire ^ (TIMEOUT_CYCLES != 0);
`endif

  assign o_job_ready = !fifo_full;
  assign o_empty     = fifo_empty;
  assign o_run       = run_q;
  assign o_busy      = busy_q;
  assign o_num_cnt   = num_cnt_q;
  assign o_jobs_done = jobs_q;

endmodule
`default_nettype wire

// File: tb/tb_fsm_counter_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_fsm_counter_dispatcher
// Description : Directed self-checking bench for fsm_counter_dispatcher with a
//               small behavioural counter worker (stall / hang controls).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fsm_counter_dispatcher;

  localparam int CNT_W = 7;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             i_job_valid = 1'b0;
  logic [CNT_W-1:0] i_job_num = '0;
  logic             o_job_ready, o_run, o_busy, o_empty, o_timeout, o_err;
  logic [CNT_W-1:0] o_num_cnt;
  logic [15:0]      o_jobs_done;
  logic             i_idle, i_running, i_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fsm_counter_dispatcher #(
    .CNT_W(CNT_W), .DEPTH(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .i_job_valid(i_job_valid), .i_job_num(i_job_num), .o_job_ready(o_job_ready),
    .o_run(o_run), .o_num_cnt(o_num_cnt),
    .i_idle(i_idle), .i_running(i_running), .i_done(i_done),
    .o_busy(o_busy), .o_empty(o_empty), .o_jobs_done(o_jobs_done),
    .o_timeout(o_timeout), .o_err(o_err)
  );

  // Behavioural worker: loads the count on a run pulse, spends that many
  // cycles running, pulses done for one cycle, returns to idle.
  logic             stall = 1'b0;  // masks idle: worker looks busy
  logic             hang  = 1'b0;  // freezes the count: done never arrives
  logic [1:0]       ws;
  logic [CNT_W-1:0] wcnt;
  int               wcycles;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ws <= 2'd0; wcnt <= '0; wcycles <= 0;
    end else begin
      case (ws)
        2'd0: if (o_run) begin wcnt <= o_num_cnt; wcycles <= 0; ws <= 2'd1; end
        2'd1: if (!hang) begin
          wcycles <= wcycles + 1;
          if (wcnt == 1) ws <= 2'd2;
          else           wcnt <= wcnt - 1'b1;
        end
        default: ws <= 2'd0;
      endcase
    end
  end

  assign i_idle    = (ws == 2'd0) && !stall;
  assign i_running = (ws == 2'd1);
  assign i_done    = (ws == 2'd2);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Launch monitor: logs every launched count, checks the worker was idle,
  // pulse spacing, and that the count is still held when done arrives.
  int               launch_log[$];
  int               last_run = 0;
  bit               have_run = 1'b0;

  always @(negedge clk) begin
    if (o_run) begin
      launch_log.push_back(int'(o_num_cnt));
      check("run_while_idle", {31'd0, i_idle}, 32'd1);
      if (have_run) check("run_gap_ge3", {31'd0, (cyc - last_run) >= 3}, 32'd1);
      last_run = cyc;
      have_run = 1'b1;
    end
    if (i_done && o_busy && launch_log.size() > 0)
      check("num_hold", {25'd0, o_num_cnt}, 32'(launch_log[$]));
  end

  task automatic push_job(input logic [CNT_W-1:0] v, output logic acc);
    @(negedge clk);
    i_job_valid = 1'b1;
    i_job_num   = v;
    acc         = o_job_ready;
    @(posedge clk);
    #1;
    i_job_valid = 1'b0;
    i_job_num   = '0;
  endtask

  task automatic wait_jobs(input int n, input int budget);
    int k = 0;
    while (o_jobs_done !== 16'(n) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("jobs_done", {16'd0, o_jobs_done}, 32'(n));
  endtask

  task automatic wait_run(input int budget);
    int k = 0;
    while (o_run !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("run_seen", {31'd0, o_run}, 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (o_busy !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("busy_clear", {31'd0, o_busy}, 32'd0);
  endtask

  task automatic check_log(input int idx, input int exp);
    if (idx < launch_log.size()) check("launch_order", 32'(launch_log[idx]), 32'(exp));
    else                         check("launch_count", 32'(launch_log.size()), 32'(idx + 1));
  endtask

  logic acc;

  initial begin
    // ---- 1: reset and release ----
    repeat (3) @(negedge clk);
    check("rst_run", {31'd0, o_run}, 32'd0);
    check("rst_num", {25'd0, o_num_cnt}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rel_ready", {31'd0, o_job_ready}, 32'd1);
    check("rel_empty", {31'd0, o_empty}, 32'd1);
    check("rel_run",   {31'd0, o_run}, 32'd0);
    check("rel_busy",  {31'd0, o_busy}, 32'd0);
    check("rel_jobs",  {16'd0, o_jobs_done}, 32'd0);
    check("rel_err",   {30'd0, o_timeout, o_err}, 32'd0);

    // ---- 2: single job of 100, launch latency ----
    push_job(7'd100, acc);
    check("acc_100", {31'd0, acc}, 32'd1);
    @(negedge clk);                          // after push edge N
    check("lat_n_run",   {31'd0, o_run}, 32'd0);
    check("lat_n_empty", {31'd0, o_empty}, 32'd0);
    @(negedge clk);                          // after edge N+1: launch cycle
    check("lat_n1_run", {31'd0, o_run}, 32'd1);
    check("lat_n1_num", {25'd0, o_num_cnt}, 32'd100);
    check("lat_n1_busy", {31'd0, o_busy}, 32'd1);
    @(negedge clk);
    check("run_1cycle", {31'd0, o_run}, 32'd0);
    wait_jobs(1, 150);
    check("worker_cycles", 32'(wcycles), 32'd100);
    wait_idle(10);

    // ---- 3: fill FIFO while worker busy, zero job dropped ----
    stall = 1'b1;
    push_job(7'd5, acc); check("acc_5", {31'd0, acc}, 32'd1);
    push_job(7'd0, acc); check("acc_0", {31'd0, acc}, 32'd1);
    push_job(7'd7, acc); check("acc_7", {31'd0, acc}, 32'd1);
    check("ready_3q", {31'd0, o_job_ready}, 32'd1);
    push_job(7'd9, acc); check("acc_9", {31'd0, acc}, 32'd1);
    push_job(7'd3, acc); check("acc_3", {31'd0, acc}, 32'd1);
    @(negedge clk);
    check("full_ready", {31'd0, o_job_ready}, 32'd0);
    push_job(7'd11, acc); check("acc_full", {31'd0, acc}, 32'd0);
    check("stall_busy", {31'd0, o_busy}, 32'd0);
    stall = 1'b0;
    wait_jobs(5, 400);
    wait_idle(10);
    check_log(1, 5); check_log(2, 7); check_log(3, 9); check_log(4, 3);
    check("empty_after3", {31'd0, o_empty}, 32'd1);

    // ---- 6: push and pop on the same edge at occupancy 1 ----
    stall = 1'b1;
    push_job(7'd20, acc);
    @(negedge clk);
    check("q1_empty", {31'd0, o_empty}, 32'd0);
    i_job_valid = 1'b1;
    i_job_num   = 7'd21;
    stall       = 1'b0;                      // pop of 20 on the same edge
    @(posedge clk);
    #1;
    i_job_valid = 1'b0;
    i_job_num   = '0;
    @(negedge clk);
    check("pp_run", {31'd0, o_run}, 32'd1);
    check("pp_num", {25'd0, o_num_cnt}, 32'd20);
    check("pp_empty", {31'd0, o_empty}, 32'd0);
    wait_jobs(7, 200);
    wait_idle(10);
    check_log(5, 20); check_log(6, 21);
    check("pp_count", 32'(launch_log.size()), 32'd7);
    check("pp_drain", {31'd0, o_empty}, 32'd1);

    // ---- 4: reset during S_WAIT with two jobs queued ----
    hang = 1'b1;
    push_job(7'd30, acc);
    wait_run(10);
    push_job(7'd31, acc);
    push_job(7'd32, acc);
    repeat (2) @(negedge clk);
    check("pre_rst_busy", {31'd0, o_busy}, 32'd1);
    check("pre_rst_empty", {31'd0, o_empty}, 32'd0);
    reset_n = 1'b0;
    #1;
    check("arst_run",   {31'd0, o_run}, 32'd0);
    check("arst_num",   {25'd0, o_num_cnt}, 32'd0);
    check("arst_jobs",  {16'd0, o_jobs_done}, 32'd0);
    check("arst_busy",  {31'd0, o_busy}, 32'd0);
    check("arst_empty", {31'd0, o_empty}, 32'd1);
    check("arst_ready", {31'd0, o_job_ready}, 32'd1);
    check("arst_err",   {30'd0, o_timeout, o_err}, 32'd0);
    hang = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_launches", 32'(launch_log.size()), 32'd8);
    check("post_rst_busy", {31'd0, o_busy}, 32'd0);

`ifdef FSM_DISPATCH_TIMEOUT_EN
    // ---- 5: watchdog expiry, then a normal job ----
    begin
      int t0;
      int k;
      hang = 1'b1;
      push_job(7'd40, acc);
      wait_run(10);
      t0 = cyc;
      k  = 0;
      while (o_timeout !== 1'b1 && k < 40) begin
        @(negedge clk);
        k++;
      end
      // Run cycle, then 16 cycles in S_WAIT, pulse on the following cycle.
      check("to_delay", 32'(cyc - t0), 32'd17);
      check("to_err", {31'd0, o_err}, 32'd1);
      @(negedge clk);
      check("to_pulse1", {31'd0, o_timeout}, 32'd0);
      check("to_sticky", {31'd0, o_err}, 32'd1);
      check("to_notcounted", {16'd0, o_jobs_done}, 32'd0);
      hang = 1'b0;
      push_job(7'd41, acc);
      wait_jobs(1, 200);
      check_log(9, 41);
      check("to_err_kept", {31'd0, o_err}, 32'd1);
    end
`else
    check("no_wd_timeout", {31'd0, o_timeout}, 32'd0);
    check("no_wd_err", {31'd0, o_err}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
